sdram_responder: RTL and testbench
==================================

SDRAM_RESPONDER -- requirements
Module: sdram_responder

Interface
REQ-001 SHALL have parameter ROW_SEL, default 4, giving the number of low row bits used for storage indexing.
REQ-002 SHALL have parameter COL_SEL, default 6, giving the number of low column bits used for storage indexing; storage is 2^(2+ROW_SEL+COL_SEL) x 16 bit, indexed {BA, row[ROW_SEL-1:0], col[COL_SEL-1:0]}.
REQ-003 SHALL have parameter T_RFC, default 6: minimum cycles from REFRESH to the next non-NOP command.
REQ-004 SHALL have ports: clk in 1, the single clock; init in 1, reset, synchronous, active-high.
REQ-005 SHALL have ports: SDRAM_A in 13; SDRAM_BA in 2; SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE in 1 each; SDRAM_DQML, SDRAM_DQMH in 1 each; SDRAM_CKE in 1.
REQ-006 SHALL have port SDRAM_DQ inout 16, driven per byte only during read data cycles, else Z.
REQ-007 SHALL have outputs: mode_reg out 13, last loaded mode; initialized out 1; rfsh_count out 16, accepted REFRESH count.
REQ-008 SHALL have outputs err_proto, err_timing, err_mode, each out 1 and sticky.

Function
REQ-009 SHALL sample all inputs on rising clk; a command is decoded only when nCS=0 and CKE=1, else NOP.
REQ-010 SHALL decode {nRAS,nCAS,nWE}: 111 NOP, 110 BURST_TERMINATE (no-op), 101 READ, 100 WRITE, 011 ACTIVE, 010 PRECHARGE, 001 REFRESH, 000 LOAD_MODE.
REQ-011 SHALL keep per bank an open flag, 13-bit open row, and a cycles-since-ACTIVE counter saturating at 3.
REQ-012 ACTIVE SHALL open bank BA with row A; if the bank is already open: err_proto set, row unchanged.
REQ-013 PRECHARGE SHALL close all banks if A[10]=1, else only bank BA; precharging a closed bank is legal.
REQ-014 READ/WRITE to a closed bank, or before initialized=1, SHALL set err_proto and have no other effect.
REQ-015 READ/WRITE issued <2 cycles after ACTIVE to the same bank SHALL set err_timing and still execute.
REQ-016 WRITE SHALL store SDRAM_DQ sampled on the command edge: low byte if DQML=0, high byte if DQMH=0; column = A[8:0].
REQ-017 READ sampled at edge S SHALL present the stored word so that it is stable at edge S+CL: drive from edge S+CL-1, release at edge S+CL.
REQ-018 Read pipeline SHALL be a CL-deep shift register carrying data and DQM masks; a read may issue every cycle; bytes with DQM=1 at READ SHALL stay Z.
REQ-019 A[10]=1 on READ/WRITE SHALL close the bank after the access (auto-precharge).
REQ-020 CL SHALL be mode_reg[6:4]; values 2 and 3 are legal; any other value sets err_mode and uses CL=2.
REQ-021 mode_reg[2:0]!=000 (burst>1) or mode_reg[8:7]!=00 SHALL set err_mode; burst length 1 is always used.
REQ-022 LOAD_MODE SHALL set mode_reg<=A only when all banks are closed; otherwise set err_proto and keep mode_reg.
REQ-023 REFRESH SHALL require all banks closed, else set err_proto; when accepted, rfsh_count increments, saturating at FFFF.
REQ-024 Any non-NOP command <T_RFC cycles after REFRESH SHALL set err_timing and still execute.
REQ-025 initialized SHALL set on an accepted LOAD_MODE after at least one PRECHARGE with A[10]=1 and two accepted REFRESH since reset; it stays 1 until init.
REQ-026 A WRITE sampled while the read pipeline drives the same edge SHALL set err_proto, release the bus that cycle, and perform the write.
REQ-027 Storage contents SHALL not be cleared by init.

Reset
REQ-028 On init: banks closed, counters cleared, mode_reg=0, initialized=0, rfsh_count=0, all err_* =0, read pipeline flushed, SDRAM_DQ Z from the next cycle.
REQ-029 init during an in-flight read SHALL drop the read; no data is driven afterwards.

Verification
REQ-030 Run the init sequence PRECHARGE A[10]=1, REFRESH, REFRESH, LOAD_MODE A=0x220 -> initialized=1, mode_reg=0x220, rfsh_count=2, no err.
REQ-031 Bench SHALL cover: ACTIVE BA=1 row 5; 2 cycles later WRITE col 3 DQ=0xBEEF DQM=00; ACTIVE, READ col 3 -> 0xBEEF stable at read edge+2; with CL=3 -> at edge+3.
REQ-032 Bench SHALL cover: WRITE 0x1234 DQMH=1, DQML=0 over a stored 0xAAAA -> read returns 0xAA34.
REQ-033 Bench SHALL cover: READ 1 cycle after ACTIVE -> err_timing=1; READ to closed bank -> err_proto=1, bus stays Z.
REQ-034 Bench SHALL cover: LOAD_MODE with A[6:4]=5 -> err_mode=1, reads use CL=2; REFRESH then ACTIVE 3 cycles later -> err_timing=1.
REQ-035 Bench SHALL cover: init asserted one cycle after READ at CL=3 -> SDRAM_DQ never driven, all flags 0, prior storage intact on re-read.

Source files
------------

// File: rtl/sdram_responder.sv
// Behavioural SDR SDRAM target: single-word bursts, sticky protocol/timing/mode checkers.
// Read data is driven CL (2 or 3) cycles after the READ edge; there is no backpressure, one command per cycle.
module sdram_responder #(
    parameter int ROW_SEL = 4,
    parameter int COL_SEL = 6,
    parameter int T_RFC   = 6
) (
    input  logic        clk,
    input  logic        init,
    input  logic [12:0] SDRAM_A,
    input  logic [1:0]  SDRAM_BA,
    input  logic        SDRAM_nCS,
    input  logic        SDRAM_nRAS,
    input  logic        SDRAM_nCAS,
    input  logic        SDRAM_nWE,
    input  logic        SDRAM_DQML,
    input  logic        SDRAM_DQMH,
    input  logic        SDRAM_CKE,
    inout  wire  [15:0] SDRAM_DQ,
    output logic [12:0] mode_reg,
    output logic        initialized,
    output logic [15:0] rfsh_count,
    output logic        err_proto,
    output logic        err_timing,
    output logic        err_mode
);
    localparam int AW   = 2 + ROW_SEL + COL_SEL;
    localparam int RFCW = $clog2(T_RFC + 1);
    localparam logic [RFCW-1:0] RFC_MAX = RFCW'(T_RFC);

    // BURST_TERMINATE (110) falls through the case below as a no-op.
    localparam logic [2:0] CMD_NOP   = 3'b111;
    localparam logic [2:0] CMD_READ  = 3'b101;
    localparam logic [2:0] CMD_WRITE = 3'b100;
    localparam logic [2:0] CMD_ACT   = 3'b011;
    localparam logic [2:0] CMD_PRE   = 3'b010;
    localparam logic [2:0] CMD_REF   = 3'b001;
    localparam logic [2:0] CMD_LMR   = 3'b000;

    logic [15:0]     r_mem [0:(1<<AW)-1];
    logic [3:0]      r_open;
    logic [12:0]     r_row [0:3];
    logic [1:0]      r_act_cnt [0:3];
    logic [RFCW-1:0] r_rfc;
    logic            r_pall_seen;
    logic [2:0]      r_pv;
    logic [15:0]     r_pd [0:2];
    logic [1:0]      r_pm [0:2];

    logic [2:0]    w_cmd;
    logic [12:0]   w_row;
    logic [AW-1:0] w_addr;
    logic [1:0]    w_cl;
    logic          w_acc_ok;
    logic          w_oe_lo;
    logic          w_oe_hi;
    logic          w_collide;
    logic          w_wr_en;
    logic          w_mode_bad;
    logic          w_unused_row;

    assign w_cmd      = (!SDRAM_nCS && SDRAM_CKE) ? {SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE} : CMD_NOP;
    assign w_row      = r_row[SDRAM_BA];
    assign w_addr     = {SDRAM_BA, w_row[ROW_SEL-1:0], SDRAM_A[COL_SEL-1:0]};
    assign w_cl       = (mode_reg[6:4] == 3'd3) ? 2'd3 : 2'd2;
    assign w_acc_ok   = initialized && r_open[SDRAM_BA];
    assign w_oe_lo    = r_pv[0] && !r_pm[0][0];
    assign w_oe_hi    = r_pv[0] && !r_pm[0][1];
    assign w_collide  = (w_cmd == CMD_WRITE) && (w_oe_lo || w_oe_hi);
    assign w_wr_en    = (w_cmd == CMD_WRITE) && w_acc_ok && !init;
    assign w_mode_bad = ((SDRAM_A[6:4] != 3'd2) && (SDRAM_A[6:4] != 3'd3))
                        || (SDRAM_A[2:0] != 3'd0) || (SDRAM_A[8:7] != 2'd0);
    assign w_unused_row = ^w_row[12:ROW_SEL];

    assign SDRAM_DQ[7:0]  = w_oe_lo ? r_pd[0][7:0]  : 8'bz;
    assign SDRAM_DQ[15:8] = w_oe_hi ? r_pd[0][15:8] : 8'bz;

    // Storage survives init on purpose.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            if (!SDRAM_DQML) r_mem[w_addr][7:0]  <= SDRAM_DQ[7:0];
            if (!SDRAM_DQMH) r_mem[w_addr][15:8] <= SDRAM_DQ[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            r_open      <= 4'd0;
            r_rfc       <= RFC_MAX;
            r_pall_seen <= 1'b0;
            r_pv        <= 3'd0;
            for (int b = 0; b < 4; b++) begin
                r_row[b]     <= 13'd0;
                r_act_cnt[b] <= 2'd0;
            end
            for (int i = 0; i < 3; i++) begin
                r_pd[i] <= 16'd0;
                r_pm[i] <= 2'b11;
            end
            mode_reg    <= 13'd0;
            initialized <= 1'b0;
            rfsh_count  <= 16'd0;
            err_proto   <= 1'b0;
            err_timing  <= 1'b0;
            err_mode    <= 1'b0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (r_act_cnt[b] != 2'd3) r_act_cnt[b] <= r_act_cnt[b] + 2'd1;
            if (r_rfc != RFC_MAX) r_rfc <= r_rfc + 1'b1;
            if (w_cmd != CMD_NOP && r_rfc < RFC_MAX) err_timing <= 1'b1;

            // Stage 0 is what drives the bus; reads enter at stage CL-1.
            for (int i = 0; i < 2; i++) begin
                r_pv[i] <= r_pv[i+1];
                r_pd[i] <= r_pd[i+1];
                r_pm[i] <= r_pm[i+1];
            end
            r_pv[2] <= 1'b0;

            case (w_cmd)
                CMD_ACT: begin
                    if (r_open[SDRAM_BA]) begin
                        err_proto <= 1'b1;
                    end else begin
                        r_open[SDRAM_BA]    <= 1'b1;
                        r_row[SDRAM_BA]     <= SDRAM_A;
                        r_act_cnt[SDRAM_BA] <= 2'd1;
                    end
                end
                CMD_PRE: begin
                    if (SDRAM_A[10]) begin
                        r_open      <= 4'd0;
                        r_pall_seen <= 1'b1;
                    end else begin
                        r_open[SDRAM_BA] <= 1'b0;
                    end
                end
                CMD_READ, CMD_WRITE: begin
                    if (!w_acc_ok) begin
                        err_proto <= 1'b1;
                    end else begin
                        if (r_act_cnt[SDRAM_BA] < 2'd2) err_timing <= 1'b1;
                        if (w_cmd == CMD_READ) begin
                            r_pv[w_cl - 2'd1] <= 1'b1;
                            r_pd[w_cl - 2'd1] <= r_mem[w_addr];
                            r_pm[w_cl - 2'd1] <= {SDRAM_DQMH, SDRAM_DQML};
                        end
                        if (SDRAM_A[10]) r_open[SDRAM_BA] <= 1'b0;
                    end
                end
                CMD_REF: begin
                    if (|r_open) begin
                        err_proto <= 1'b1;
                    end else begin
                        if (rfsh_count != 16'hFFFF) rfsh_count <= rfsh_count + 16'd1;
                        r_rfc <= RFCW'(1);
                    end
                end
                CMD_LMR: begin
                    if (|r_open) begin
                        err_proto <= 1'b1;
                    end else begin
                        mode_reg <= SDRAM_A;
                        if (w_mode_bad) err_mode <= 1'b1;
                        if (r_pall_seen && rfsh_count >= 16'd2) initialized <= 1'b1;
                    end
                end
                default: ;
            endcase

            // A WRITE landing on a driven edge wins the bus for the following cycle.
            if (w_collide) begin
                err_proto <= 1'b1;
                r_pv[0]   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sdram_responder.sv
// Bench for sdram_responder: directed scenarios plus random traffic against a cycle-stamped reference model.
module tb_sdram_responder;
    localparam int T_RFC = 6;
    localparam logic [2:0] C_NOP = 3'b111, C_RD = 3'b101, C_WR = 3'b100, C_ACT = 3'b011,
                           C_PRE = 3'b010, C_REF = 3'b001, C_LMR = 3'b000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        init, ncs, nras, ncas, nwe, dqml, dqmh, cke;
    logic [12:0] a;
    logic [1:0]  ba;
    wire  [15:0] dq;
    logic [15:0] tb_dq;
    logic        tb_dq_en;
    logic [12:0] mode_reg;
    logic        initialized, err_proto, err_timing, err_mode;
    logic [15:0] rfsh_count;

    assign dq = tb_dq_en ? tb_dq : 16'bz;

    sdram_responder dut (
        .clk(clk), .init(init), .SDRAM_A(a), .SDRAM_BA(ba), .SDRAM_nCS(ncs),
        .SDRAM_nRAS(nras), .SDRAM_nCAS(ncas), .SDRAM_nWE(nwe), .SDRAM_DQML(dqml),
        .SDRAM_DQMH(dqmh), .SDRAM_CKE(cke), .SDRAM_DQ(dq), .mode_reg(mode_reg),
        .initialized(initialized), .rfsh_count(rfsh_count), .err_proto(err_proto),
        .err_timing(err_timing), .err_mode(err_mode)
    );

    int n_chk = 0, n_pass = 0, cyc = 0;

    // Reference model: bank state with absolute timestamps, sparse memory, expected bus per cycle.
    bit          m_open [4];
    int          m_row [4];
    int          m_act_t [4];
    int          m_ref_t, m_rfsh;
    logic [12:0] m_mode;
    bit          m_init, m_pall, m_ep, m_et, m_em;
    logic [15:0] m_mem [int];
    logic [15:0] exp_val [int];
    bit   [1:0]  exp_oe [int];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
        else n_pass++;
    endtask

    function automatic int mkey(input int b, input int row, input int col);
        return (b << 10) | ((row & 15) << 6) | (col & 63);
    endfunction

    function automatic bit any_open();
        return m_open[0] | m_open[1] | m_open[2] | m_open[3];
    endfunction

    task automatic model_edge(input bit rst, input logic [2:0] c_in, input bit cs_n, input int b,
                              input logic [12:0] ad, input logic [15:0] d, input logic [1:0] dqm);
        logic [2:0]  c;
        logic [15:0] w;
        int          k, cl;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_open[i] = 0;
            m_ref_t = -1000; m_mode = 0; m_init = 0; m_rfsh = 0; m_pall = 0;
            m_ep = 0; m_et = 0; m_em = 0;
            exp_val.delete(); exp_oe.delete();
            return;
        end
        c = cs_n ? C_NOP : c_in;
        if (c != C_NOP && cyc - m_ref_t < T_RFC) m_et = 1;
        if (c == C_WR && exp_oe.exists(cyc - 1) && exp_oe[cyc - 1] != 2'b00) begin
            m_ep = 1;
            exp_oe.delete(cyc);
        end
        case (c)
            C_ACT: if (m_open[b]) m_ep = 1;
                   else begin m_open[b] = 1; m_row[b] = int'(ad); m_act_t[b] = cyc; end
            C_PRE: if (ad[10]) begin
                       for (int i = 0; i < 4; i++) m_open[i] = 0;
                       m_pall = 1;
                   end else m_open[b] = 0;
            C_RD, C_WR: begin
                if (!m_init || !m_open[b]) m_ep = 1;
                else begin
                    if (cyc - m_act_t[b] < 2) m_et = 1;
                    k = mkey(b, m_row[b], int'(ad[8:0]));
                    if (c == C_RD) begin
                        cl = (m_mode[6:4] == 3'd3) ? 3 : 2;
                        exp_val[cyc + cl - 1] = m_mem.exists(k) ? m_mem[k] : 16'hxxxx;
                        exp_oe[cyc + cl - 1]  = ~dqm;
                    end else begin
                        w = m_mem.exists(k) ? m_mem[k] : 16'hxxxx;
                        if (!dqm[0]) w[7:0]  = d[7:0];
                        if (!dqm[1]) w[15:8] = d[15:8];
                        m_mem[k] = w;
                    end
                    if (ad[10]) m_open[b] = 0;
                end
            end
            C_REF: if (any_open()) m_ep = 1;
                   else begin if (m_rfsh < 65535) m_rfsh++; m_ref_t = cyc; end
            C_LMR: if (any_open()) m_ep = 1;
                   else begin
                       m_mode = ad;
                       if (!(ad[6:4] == 3'd2 || ad[6:4] == 3'd3) || ad[2:0] != 0 || ad[8:7] != 0) m_em = 1;
                       if (m_pall && m_rfsh >= 2) m_init = 1;
                   end
            default: ;
        endcase
    endtask

    task automatic check_outputs();
        logic [15:0] e;
        e = 16'bz;
        if (exp_oe.exists(cyc)) begin
            if (exp_oe[cyc][0]) e[7:0]  = exp_val[cyc][7:0];
            if (exp_oe[cyc][1]) e[15:8] = exp_val[cyc][15:8];
        end
        chk("dq", dq, e);
        chk("mode_reg", mode_reg, m_mode);
        chk("initialized", initialized, m_init);
        chk("rfsh_count", rfsh_count, m_rfsh[15:0]);
        chk("err_proto", err_proto, m_ep);
        chk("err_timing", err_timing, m_et);
        chk("err_mode", err_mode, m_em);
    endtask

    task automatic tick(input logic [2:0] c, input int b, input logic [12:0] ad, input logic [15:0] d,
                        input logic [1:0] dqm, input bit cs_n, input bit rst);
        init = rst; ncs = cs_n; {nras, ncas, nwe} = c; ba = b[1:0]; a = ad; {dqmh, dqml} = dqm;
        tb_dq = d; tb_dq_en = !cs_n && (c == C_WR);
        @(posedge clk);
        cyc++;
        model_edge(rst, c, cs_n, b, ad, d, dqm);
        #1;
        init = 0; ncs = 1; {nras, ncas, nwe} = C_NOP; tb_dq_en = 0;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic nop(input int n);
        repeat (n) tick(C_NOP, 0, 13'd0, 16'd0, 2'b00, 1'b0, 1'b0);
    endtask
    task automatic act(input int b, input int row);
        tick(C_ACT, b, 13'(row), 16'd0, 2'b00, 1'b0, 1'b0);
    endtask
    task automatic rd(input int b, input int col, input bit ap, input logic [1:0] dqm);
        tick(C_RD, b, 13'(col) | (ap ? 13'h400 : 13'h0), 16'd0, dqm, 1'b0, 1'b0);
    endtask
    task automatic wr(input int b, input int col, input bit ap, input logic [15:0] d, input logic [1:0] dqm);
        tick(C_WR, b, 13'(col) | (ap ? 13'h400 : 13'h0), d, dqm, 1'b0, 1'b0);
    endtask
    task automatic pre(input int b, input bit all);
        tick(C_PRE, b, all ? 13'h400 : 13'h0, 16'd0, 2'b00, 1'b0, 1'b0);
    endtask
    task automatic refr();
        tick(C_REF, 0, 13'd0, 16'd0, 2'b00, 1'b0, 1'b0);
    endtask
    task automatic lmr(input logic [12:0] m);
        tick(C_LMR, 0, m, 16'd0, 2'b00, 1'b0, 1'b0);
    endtask
    task automatic rst_dut();
        repeat (2) tick(C_NOP, 0, 13'd0, 16'd0, 2'b00, 1'b1, 1'b1);
    endtask
    task automatic init_seq(input logic [12:0] m);
        pre(0, 1); nop(1); refr(); nop(6); refr(); nop(6); lmr(m); nop(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          sel, rb, rrow, rcol;
        bit          rap;
        logic [1:0]  rdqm;
        init = 1; ncs = 1; {nras, ncas, nwe} = C_NOP; a = 0; ba = 0; dqml = 1; dqmh = 1;
        cke = 1; tb_dq = 0; tb_dq_en = 0;

        // Power-up sequence, then write/read at CL2 and CL3.
        rst_dut();
        init_seq(13'h220);
        act(1, 5); nop(1); wr(1, 3, 1, 16'hBEEF, 2'b00);
        act(1, 5); nop(1); rd(1, 3, 1, 2'b00); nop(3);
        lmr(13'h230); nop(1);
        act(1, 5); nop(1); rd(1, 3, 1, 2'b00); nop(4);

        // Byte-masked write and back-to-back reads, one with a masked byte.
        act(0, 2); nop(1);
        wr(0, 7, 0, 16'hAAAA, 2'b00);
        wr(0, 7, 0, 16'h1234, 2'b10);
        rd(0, 7, 0, 2'b00); rd(0, 7, 1, 2'b01); nop(4);

        // READ one cycle after ACTIVE.
        rst_dut(); init_seq(13'h220);
        act(1, 5); rd(1, 3, 1, 2'b00); nop(3);

        // READ to a closed bank.
        rst_dut(); init_seq(13'h220);
        rd(2, 0, 0, 2'b00); nop(3);

        // Illegal CAS latency falls back to 2; ACTIVE too soon after REFRESH.
        rst_dut(); init_seq(13'h220);
        lmr(13'h250);
        act(1, 5); nop(1); rd(1, 3, 1, 2'b00); nop(1);
        refr(); nop(2); act(2, 0); pre(2, 0); nop(6);

        // init one cycle after a CL3 READ drops it; storage survives.
        rst_dut(); init_seq(13'h230);
        act(1, 5); nop(1); rd(1, 3, 0, 2'b00);
        tick(C_NOP, 0, 13'd0, 16'd0, 2'b00, 1'b0, 1'b1);
        nop(5);
        init_seq(13'h220);
        act(1, 5); nop(1); rd(1, 3, 1, 2'b00); nop(3);

        // Random traffic over a prefilled window of banks 0-3, rows 0-1, columns 0-3.
        rst_dut();
        init_seq(($urandom_range(0, 1) == 1) ? 13'h230 : 13'h220);
        for (int b = 0; b < 4; b++)
            for (int r = 0; r < 2; r++) begin
                act(b, r); nop(1);
                for (int c = 0; c < 4; c++) wr(b, c, c == 3, 16'($urandom), 2'b00);
            end
        for (int i = 0; i < 500; i++) begin
            sel  = $urandom_range(0, 19);
            rb   = $urandom_range(0, 3);
            rrow = $urandom_range(0, 1);
            rcol = $urandom_range(0, 3);
            rap  = ($urandom_range(0, 3) == 0);
            rdqm = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if (sel >= 13 && sel <= 16 && exp_oe.exists(cyc) && exp_oe[cyc] != 2'b00) sel = 0;
            if (sel <= 3)       nop(1);
            else if (sel == 4)  tick(C_RD, rb, 13'(rcol), 16'd0, 2'b00, 1'b1, 1'b0);
            else if (sel <= 7)  act(rb, rrow);
            else if (sel <= 12) rd(rb, rcol, rap, rdqm);
            else if (sel <= 16) wr(rb, rcol, rap, 16'($urandom), rdqm);
            else if (sel <= 18) pre(rb, rap);
            else                refr();
        end
        nop(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
